// File: rtl/mc_pkg.sv
// mc_pkg: shared types and default sizing for the multicast scheduler.
//   mc_state_t      - CFG (table programming) / RUN (arbitration) phase
//   *_DEF constants - default parameter values used by multicast_scheduler
package mc_pkg;

  typedef enum logic {CFG = 1'b0, RUN = 1'b1} mc_state_t;

  localparam int PE_COUNT_DEF   = 5;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int ID_WIDTH_DEF   = 4;
  localparam int NUM_SRC_DEF    = 3;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   elig      in  [N]  : requesters that may be granted this cycle
//   ptr       in  [PW] : highest-priority index (search starts here, wraps)
//   grant     out [N]  : one-hot grant, all-zero when nothing is eligible
//   grant_idx out [PW] : index of the granted requester (0 when none)
// The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/multicast_scheduler.sv
// multicast_scheduler: owns the router's PE ID table and arbitrates several
// source streams onto one multicast bus, one tagged word per cycle.
//   clk, rst                      : clock, synchronous active-high reset
//   src_valid/src_data/src_tag    : per-source request, payload, destination tag
//   src_ready                     : per-source grant (combinational)
//   pe_ready                      : per-PE input buffer has room
//   cfg_we/cfg_idx/cfg_id         : ID table write port (CFG phase only)
//   cfg_done / cfg_clear          : CFG->RUN / RUN->CFG pulses
//   in_val/tag_id/in_valid        : registered word to the router
//   pe_ids                        : ID table driven to the router
//   err_nomatch                   : pulse, a granted word matched no PE and was dropped
//   running                       : high in RUN
module multicast_scheduler
  import mc_pkg::*;
#(
  parameter int PE_COUNT   = PE_COUNT_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ID_WIDTH   = ID_WIDTH_DEF,
  parameter int NUM_SRC    = NUM_SRC_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  src_valid,
  input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]  src_data,
  input  logic [NUM_SRC-1:0][ID_WIDTH-1:0]    src_tag,
  output logic [NUM_SRC-1:0]                  src_ready,
  input  logic [PE_COUNT-1:0]                 pe_ready,
  input  logic                                cfg_we,
  input  logic [$clog2(PE_COUNT)-1:0]         cfg_idx,
  input  logic [ID_WIDTH-1:0]                 cfg_id,
  input  logic                                cfg_done,
  input  logic                                cfg_clear,
  output logic [DATA_WIDTH-1:0]               in_val,
  output logic [ID_WIDTH-1:0]                 tag_id,
  output logic                                in_valid,
  output logic [PE_COUNT-1:0][ID_WIDTH-1:0]   pe_ids,
  output logic                                err_nomatch,
  output logic                                running
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IDX_W = $clog2(PE_COUNT);

  mc_state_t                          state_reg;
  logic [PE_COUNT-1:0][ID_WIDTH-1:0]  pe_ids_reg;
  logic [PTR_W-1:0]                   ptr_reg;
  logic [DATA_WIDTH-1:0]              in_val_reg;
  logic [ID_WIDTH-1:0]                tag_id_reg;
  logic                               in_valid_reg;
  logic                               err_nomatch_reg;

  logic [NUM_SRC-1:0][PE_COUNT-1:0]   match;
  logic [NUM_SRC-1:0]                 has_match;
  logic [NUM_SRC-1:0]                 eligible;
  logic [NUM_SRC-1:0]                 arb_elig;
  logic [NUM_SRC-1:0]                 grant;
  logic [PTR_W-1:0]                   grant_idx;
  logic                               arb_en;
  logic                               any_grant;
  logic                               issue;

  // Per-source match set and "all targets ready" reduction. A source whose
  // tag matches no PE is eligible so that it can be consumed and flagged.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    for (genvar gj = 0; gj < PE_COUNT; gj++) begin : g_pe
      assign match[gi][gj] = (pe_ids_reg[gj] == src_tag[gi]);
    end
    assign has_match[gi] = |match[gi];
    assign eligible[gi]  = src_valid[gi] & (&(~match[gi] | pe_ready));
  end

  // No grants outside RUN, in the cfg_clear cycle, or while reset is held.
  assign arb_en   = (state_reg == RUN) & ~cfg_clear & ~rst;
  assign arb_elig = eligible & {NUM_SRC{arb_en}};

  rr_arbiter #(.N(NUM_SRC), .PW(PTR_W)) u_arb (
    .elig      (arb_elig),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign any_grant = |grant;
  assign issue     = any_grant & has_match[grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CFG;
    end else if (state_reg == CFG && cfg_done) begin
      state_reg <= RUN;
    end else if (state_reg == RUN && cfg_clear) begin
      state_reg <= CFG;
    end
  end

  // ID table: out-of-range cfg_idx matches no entry and is thereby ignored.
  for (genvar gi = 0; gi < PE_COUNT; gi++) begin : g_tbl
    always_ff @(posedge clk) begin
      if (rst) begin
        pe_ids_reg[gi] <= ID_WIDTH'(gi);
      end else if (state_reg == CFG && cfg_we && cfg_idx == IDX_W'(gi)) begin
        pe_ids_reg[gi] <= cfg_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= '0;
      in_val_reg      <= '0;
      tag_id_reg      <= '0;
      in_valid_reg    <= 1'b0;
      err_nomatch_reg <= 1'b0;
    end else begin
      in_valid_reg    <= issue;
      err_nomatch_reg <= any_grant & ~has_match[grant_idx];
      if (any_grant) begin
        ptr_reg <= (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (issue) begin
        in_val_reg <= src_data[grant_idx];
        tag_id_reg <= src_tag[grant_idx];
      end
    end
  end

  assign src_ready   = grant;
  assign in_val      = in_val_reg;
  assign tag_id      = tag_id_reg;
  assign in_valid    = in_valid_reg;
  assign err_nomatch = err_nomatch_reg;
  assign pe_ids      = pe_ids_reg;
  assign running     = (state_reg == RUN);

endmodule

// File: tb/tb_multicast_scheduler.sv
// Directed testbench for multicast_scheduler (default parameters).
module tb_multicast_scheduler;

  logic             clk;
  logic             rst;
  logic [2:0]       src_valid;
  logic [2:0][15:0] src_data;
  logic [2:0][3:0]  src_tag;
  logic [2:0]       src_ready;
  logic [4:0]       pe_ready;
  logic             cfg_we;
  logic [2:0]       cfg_idx;
  logic [3:0]       cfg_id;
  logic             cfg_done;
  logic             cfg_clear;
  logic [15:0]      in_val;
  logic [3:0]       tag_id;
  logic             in_valid;
  logic [4:0][3:0]  pe_ids;
  logic             err_nomatch;
  logic             running;

  int tests_run;
  int tests_failed;

  multicast_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_tag     (src_tag),
    .src_ready   (src_ready),
    .pe_ready    (pe_ready),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_id      (cfg_id),
    .cfg_done    (cfg_done),
    .cfg_clear   (cfg_clear),
    .in_val      (in_val),
    .tag_id      (tag_id),
    .in_valid    (in_valid),
    .pe_ids      (pe_ids),
    .err_nomatch (err_nomatch),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    src_valid = 3'b111;
    src_tag[0] = 4'd0; src_tag[1] = 4'd1; src_tag[2] = 4'd2;
    pe_ready = 5'b11111;
    tick();
    tick();
    for (int p = 0; p < 5; p++) begin
      tests_run++;
      if (pe_ids[p] !== 4'(p)) begin
        tests_failed++;
        $display("FAIL reset_pe_ids[%0d]: got %0d expected %0d", p, pe_ids[p], p);
      end
    end
    tests_run++;
    if ({in_valid, in_val, tag_id, err_nomatch, running} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: in_valid=%b in_val=%h tag_id=%h err=%b running=%b expected all 0",
               in_valid, in_val, tag_id, err_nomatch, running);
    end
    tests_run++;
    if (src_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_src_ready_in_rst: got %b expected 000", src_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (src_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_src_ready_cfg: got %b expected 000", src_ready);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_config();
    logic [3:0] exp_ids [5];
    exp_ids[0] = 4'd0; exp_ids[1] = 4'd1; exp_ids[2] = 4'd7;
    exp_ids[3] = 4'd3; exp_ids[4] = 4'd4;
    src_valid = 3'b000;
    // cfg_clear while already in CFG must be ignored
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_we = 1'b1; cfg_idx = 3'd2; cfg_id = 4'd7;
    tick();
    cfg_idx = 3'd5; cfg_id = 4'd9;
    tick();
    cfg_we = 1'b0;
    tests_run++;
    if (running !== 1'b0) begin
      tests_failed++;
      $display("FAIL config_still_cfg: running=%b expected 0", running);
    end
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    for (int p = 0; p < 5; p++) begin
      tests_run++;
      if (pe_ids[p] !== exp_ids[p]) begin
        tests_failed++;
        $display("FAIL config_pe_ids[%0d]: got %0d expected %0d", p, pe_ids[p], exp_ids[p]);
      end
    end
    tests_run++;
    if (running !== 1'b1) begin
      tests_failed++;
      $display("FAIL config_running: got %b expected 1", running);
    end
    // cfg_we in RUN is ignored; cfg_done in RUN is ignored
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_id = 4'd12; cfg_done = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_done = 1'b0;
    tests_run++;
    if (pe_ids[0] !== 4'd0 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL config_we_in_run: pe_ids[0]=%0d running=%b expected 0 and 1", pe_ids[0], running);
    end
    $display("[TB] test_config done");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_order [4];
    logic [15:0] dat [3];
    logic [3:0]  tg [3];
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2; exp_order[3] = 2'd0;
    dat[0] = 16'hBEEF; dat[1] = 16'h1234; dat[2] = 16'h5678;
    tg[0] = 4'd0; tg[1] = 4'd1; tg[2] = 4'd3;
    for (int s = 0; s < 3; s++) begin
      src_data[s] = dat[s];
      src_tag[s]  = tg[s];
    end
    pe_ready  = 5'b11111;
    src_valid = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      tests_run++;
      if (src_ready !== (3'b001 << exp_order[c])) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: src_ready=%b expected %b", c, src_ready, 3'b001 << exp_order[c]);
      end
      tick();
      tests_run++;
      if (in_valid !== 1'b1 || in_val !== dat[exp_order[c]] || tag_id !== tg[exp_order[c]]) begin
        tests_failed++;
        $display("FAIL rr_issue_%0d: in_valid=%b in_val=%h tag_id=%0d expected 1 %h %0d",
                 c, in_valid, in_val, tag_id, dat[exp_order[c]], tg[exp_order[c]]);
      end
    end
    src_valid = 3'b000;
    tick();
    tests_run++;
    if (in_valid !== 1'b0 || in_val !== 16'hBEEF || tag_id !== 4'd0) begin
      tests_failed++;
      $display("FAIL rr_idle_hold: in_valid=%b in_val=%h tag_id=%0d expected 0 beef 0", in_valid, in_val, tag_id);
    end
    $display("[TB] test_round_robin done");
  endtask

  task automatic test_backpressure();
    // pointer is 1 here; reprogram table to {2,2,1,3,4}
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
    cfg_we = 1'b1; cfg_idx = 3'd0; cfg_id = 4'd2;
    tick();
    cfg_idx = 3'd1; cfg_id = 4'd2;
    tick();
    // write in the cfg_done cycle still lands
    cfg_idx = 3'd2; cfg_id = 4'd1; cfg_done = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_done = 1'b0;
    tests_run++;
    if (pe_ids[2] !== 4'd1 || running !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_cfg_done_write: pe_ids[2]=%0d running=%b expected 1 1", pe_ids[2], running);
    end
    // move pointer 1 -> 0 with a single src2 grant (tag 3 -> PE3)
    src_tag[2] = 4'd3; src_data[2] = 16'h0222;
    src_valid = 3'b100;
    #1;
    tests_run++;
    if (src_ready !== 3'b100) begin
      tests_failed++;
      $display("FAIL bp_setup_grant: src_ready=%b expected 100", src_ready);
    end
    tick();
    // src0 tag2 -> PEs {0,1}; src1 tag1 -> PE2; PE1 busy
    src_tag[0] = 4'd2; src_data[0] = 16'hA000;
    src_tag[1] = 4'd1; src_data[1] = 16'hB111;
    src_valid = 3'b011;
    pe_ready = 5'b11101;
    #1;
    tests_run++;
    if (src_ready !== 3'b010) begin
      tests_failed++;
      $display("FAIL bp_skip_src0: src_ready=%b expected 010", src_ready);
    end
    tick();
    tests_run++;
    if (in_valid !== 1'b1 || in_val !== 16'hB111 || tag_id !== 4'd1) begin
      tests_failed++;
      $display("FAIL bp_issue_src1: in_valid=%b in_val=%h tag_id=%0d expected 1 b111 1", in_valid, in_val, tag_id);
    end
    pe_ready = 5'b11111;
    #1;
    tests_run++;
    if (src_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL bp_grant_src0: src_ready=%b expected 001", src_ready);
    end
    tick();
    tests_run++;
    if (in_valid !== 1'b1 || in_val !== 16'hA000 || tag_id !== 4'd2) begin
      tests_failed++;
      $display("FAIL bp_issue_src0: in_valid=%b in_val=%h tag_id=%0d expected 1 a000 2", in_valid, in_val, tag_id);
    end
    // only src0 valid and PE0 busy: nothing eligible
    src_valid = 3'b001;
    pe_ready = 5'b11110;
    #1;
    tests_run++;
    if (src_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL bp_all_blocked: src_ready=%b expected 000", src_ready);
    end
    tick();
    tests_run++;
    if (in_valid !== 1'b0 || err_nomatch !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_no_issue: in_valid=%b err=%b expected 0 0", in_valid, err_nomatch);
    end
    src_valid = 3'b000;
    pe_ready = 5'b11111;
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_no_match();
    // pointer is 1; only src2 with unmatched tag 9
    src_tag[2] = 4'd9; src_data[2] = 16'hDEAD;
    src_valid = 3'b100;
    pe_ready = 5'b00000;
    #1;
    tests_run++;
    if (src_ready !== 3'b100) begin
      tests_failed++;
      $display("FAIL nomatch_grant: src_ready=%b expected 100", src_ready);
    end
    tick();
    src_valid = 3'b000;
    tests_run++;
    if (in_valid !== 1'b0 || err_nomatch !== 1'b1 || in_val !== 16'hA000) begin
      tests_failed++;
      $display("FAIL nomatch_drop: in_valid=%b err=%b in_val=%h expected 0 1 a000", in_valid, err_nomatch, in_val);
    end
    tick();
    tests_run++;
    if (err_nomatch !== 1'b0) begin
      tests_failed++;
      $display("FAIL nomatch_pulse: err=%b expected 0", err_nomatch);
    end
    pe_ready = 5'b11111;
    $display("[TB] test_no_match done");
  endtask

  task automatic test_mode_switch();
    // pointer 0; src0 tag2, src1 tag1, src2 tag3 all matchable
    src_tag[2] = 4'd3; src_data[2] = 16'hC333;
    src_valid = 3'b111;
    #1;
    tests_run++;
    if (src_ready !== 3'b001) begin
      tests_failed++;
      $display("FAIL ms_pre_grant: src_ready=%b expected 001", src_ready);
    end
    tick();
    cfg_clear = 1'b1;
    #1;
    tests_run++;
    if (src_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL ms_clear_ready: src_ready=%b expected 000", src_ready);
    end
    tests_run++;
    if (in_valid !== 1'b1 || in_val !== 16'hA000) begin
      tests_failed++;
      $display("FAIL ms_prior_issue: in_valid=%b in_val=%h expected 1 a000", in_valid, in_val);
    end
    tick();
    cfg_clear = 1'b0;
    #1;
    tests_run++;
    if (running !== 1'b0 || in_valid !== 1'b0 || src_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL ms_in_cfg: running=%b in_valid=%b src_ready=%b expected 0 0 000", running, in_valid, src_ready);
    end
    src_valid = 3'b000;
    $display("[TB] test_mode_switch done");
  endtask

  task automatic test_reset_mid();
    cfg_done = 1'b1;
    tick();
    cfg_done = 1'b0;
    src_valid = 3'b111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    src_valid = 3'b000;
    tests_run++;
    if (in_valid !== 1'b0 || running !== 1'b0 || pe_ids[2] !== 4'd2 || in_val !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: in_valid=%b running=%b pe_ids[2]=%0d in_val=%h expected 0 0 2 0",
               in_valid, running, pe_ids[2], in_val);
    end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    src_valid = '0; src_data = '0; src_tag = '0; pe_ready = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_id = '0; cfg_done = 1'b0; cfg_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_config();
    test_round_robin();
    test_backpressure();
    test_no_match();
    test_mode_switch();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicast_scheduler.md
# multicast_scheduler

- Controller placed in front of `MulticastRouter`.
- Owns the router's per-PE ID table (`pe_ids`) and programs it in a configuration phase.
- In run phase, arbitrates round-robin between several source streams (filter, ifmap, psum) that share the single multicast bus.
- Issues one tagged word per cycle, and only when every PE whose ID matches the tag is ready to accept it.

## Interface

Parameters:
- `PE_COUNT`, 5, number of PEs on the bus.
- `DATA_WIDTH`, 16, payload width.
- `ID_WIDTH`, 4, tag/PE-ID width.
- `NUM_SRC`, 3, number of requesting streams.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `src_valid` in [NUM_SRC]: source has a word.
- `src_data` in [NUM_SRC][DATA_WIDTH]: source payload.
- `src_tag` in [NUM_SRC][ID_WIDTH]: destination tag.
- `src_ready` out [NUM_SRC]: grant. A transfer occurs when `src_valid[i] & src_ready[i]`.
- `pe_ready` in [PE_COUNT]: PE input buffer can take a word.
- `cfg_we` in 1: write `cfg_id` into `pe_ids[cfg_idx]`.
- `cfg_idx` in `$clog2(PE_COUNT)`: table index.
- `cfg_id` in ID_WIDTH: ID value to write.
- `cfg_done` in 1: pulse that leaves CFG and enters RUN.
- `cfg_clear` in 1: pulse that leaves RUN and returns to CFG.
- `in_val` out DATA_WIDTH: router data (registered).
- `tag_id` out ID_WIDTH: router tag (registered).
- `in_valid` out 1: router strobe (registered).
- `pe_ids` out [PE_COUNT][ID_WIDTH]: ID table driven to the router.
- `err_nomatch` out 1: one-cycle pulse, a word was dropped because no PE matched its tag.
- `running` out 1: high in RUN.

## Operation

States:
- **CFG**: entered on reset.
  - `cfg_we` writes the table; writes with `cfg_idx >= PE_COUNT` are ignored.
  - All `src_ready` are 0.
  - `cfg_done` moves to RUN. A `cfg_we` in the same cycle still takes effect.
- **RUN**: arbitration is active.
  - `cfg_we` is ignored.
  - `cfg_clear` moves to CFG. `src_ready` is forced to 0 during the `cfg_clear` cycle.

Eligibility and grant:
- Match set `M(i) = {p : pe_ids[p] == src_tag[i]}`.
- Source i is eligible when `src_valid[i]` is high and either `M(i)` is empty, or every PE in `M(i)` has `pe_ready` high.
- At most one `src_ready` is high per cycle. It goes to the first eligible source at or after the round-robin pointer, wrapping modulo NUM_SRC.
- `src_ready` is combinational from `src_valid`, `src_tag`, `pe_ready` and state. It must not depend on `src_ready` itself.
- Pointer update:
  - It resets to 0.
  - After a grant to source i it becomes `(i+1) mod NUM_SRC`.
  - With no grant it is unchanged.
- An ineligible source (targets busy) is skipped this cycle. It is not starved, because the pointer moves past each winner.

Issue and drop:
- A granted word with non-empty `M` is registered onto `in_val`/`tag_id` with `in_valid`=1 for exactly one cycle.
- A granted word with empty `M` is consumed. It is not issued (`in_valid`=0 next cycle), and `err_nomatch`=1 next cycle.
- When nothing is issued, `in_valid`=0 and `in_val`/`tag_id` hold their last values.

## Timing

- Reset values:
  - State CFG.
  - `pe_ids[p] = p` (identity map).
  - `in_val`=0, `tag_id`=0, `in_valid`=0.
  - `err_nomatch`=0, `running`=0, `src_ready`=0, pointer 0.
- Latency: a grant in cycle N drives `in_valid`/`in_val`/`tag_id` in cycle N+1.
- Throughput: 1 word/cycle.
- A word granted in the `cfg_clear` cycle is impossible, since grants are forced to 0 in that cycle.
- A word granted in the cycle before `cfg_clear` is still issued.
- `pe_ids` changes are visible to eligibility one cycle after the `cfg_we` edge.
- A `cfg_done` arriving while already in RUN, or a `cfg_clear` while in CFG, is ignored.
- `rst` mid-operation: everything returns to reset values on the next edge, and no partially issued word survives.

## Structure

- Package `mc_pkg`:
  - `typedef enum logic {CFG, RUN} mc_state_t`.
  - Default-parameter localparams.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: eligibility vector and pointer.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; the pointer register lives in the parent.
- The parent holds the FSM, the ID table, the match/ready reduction per source, and the output registers.

## Test plan

- **Reset**: assert `rst` 2 cycles. Check `pe_ids` = 0..4, all outputs 0, `running`=0, and `src_valid`=3'b111 gives `src_ready`=0.
- **Config**:
  - Write `pe_ids[2]=4'd7` and `cfg_idx=5` (ignored), then `cfg_done`.
  - Check `pe_ids` = {0,1,7,3,4} and `running`=1.
- **Round robin**:
  - All 3 sources valid, tags 0/1/3, all `pe_ready` high.
  - Grants in order 0,1,2,0.
  - `in_valid` every cycle from N+1, and `in_val` equals the granted data (e.g. 16'hBEEF from src 0).
- **Backpressure**:
  - `pe_ids` = {2,2,1,3,4}; src0 tag 2, src1 tag 1; `pe_ready[1]`=0.
  - src0 is skipped and src1 is granted.
  - Raising `pe_ready[1]` grants src0 next.
- **No match**: src tag 4'd9 is granted and consumed; next cycle `in_valid`=0 and `err_nomatch`=1 for one cycle.
- **Mode switch**:
  - `cfg_clear` with all sources valid: `src_ready`=0 that cycle, state CFG after.
  - A word granted the prior cycle still appears on `in_valid`.
